// File: rtl/ram_burst_reader_pkg.sv
// Shared types and user-field layout for the burst read initiator.
package ram_burst_reader_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    // User field is {last, tag}; positions for the default tag width.
    localparam int DEFAULT_TAG_WIDTH = 4;
    localparam int LAST_BIT          = DEFAULT_TAG_WIDTH;
    localparam int TAG_MSB           = DEFAULT_TAG_WIDTH - 1;

    function automatic int last_bit(input int tag_width);
        return tag_width;
    endfunction

endpackage

// File: rtl/stream_fifo.sv
// Synchronous FIFO with valid/ready on both sides; output read from registered storage.
module stream_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    input  logic             rd_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             push;
    logic             pop;

    assign wr_ready = (count != FULL_COUNT);
    assign rd_valid = (count != '0);
    assign rd_data  = mem[rd_ptr];
    assign push     = wr_valid && wr_ready;
    assign pop      = rd_valid && rd_ready;

    // Storage is cleared on reset so the output fields read zero afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ram_burst_reader.sv
// Burst read initiator: splits commands into per-word RAM reads, credit-gated so
// returning data always has a FIFO slot, and streams the words out tagged.
module ram_burst_reader
    import ram_burst_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8,
    parameter int TAG_WIDTH  = 4,
    parameter int FIFO_DEPTH = 4,
    localparam int USER_WIDTH = TAG_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s_cmd_addr,
    input  logic [LEN_WIDTH-1:0]  s_cmd_len,
    input  logic [TAG_WIDTH-1:0]  s_cmd_tag,
    input  logic                  s_cmd_valid,
    output logic                  s_cmd_ready,
    output logic [ADDR_WIDTH-1:0] m_ram_read_addr,
    output logic [USER_WIDTH-1:0] m_ram_read_user,
    output logic                  m_ram_read_valid,
    input  logic                  m_ram_read_ready,
    input  logic [DATA_WIDTH-1:0] s_ram_read_data,
    input  logic [USER_WIDTH-1:0] s_ram_read_user,
    input  logic                  s_ram_read_valid,
    output logic                  s_ram_read_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [TAG_WIDTH-1:0]  m_tag,
    output logic                  m_last,
    output logic                  m_valid,
    input  logic                  m_ready
);

    localparam int LAST_POS = last_bit(TAG_WIDTH);
    localparam int CW       = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] CREDITS_MAX = CW'(FIFO_DEPTH);
    localparam int FW       = DATA_WIDTH + TAG_WIDTH + 1;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  count;
    logic [TAG_WIDTH-1:0]  tag;
    logic [CW-1:0]         credits;
    logic                  last_req;
    logic                  cmd_fire;
    logic                  req_fire;
    logic                  out_fire;
    logic                  rst_q;
    logic                  fifo_wr_valid;
    logic                  fifo_wr_ready;
    logic [FW-1:0]         fifo_wr_data;
    logic [FW-1:0]         fifo_rd_data;

    assign last_req = (count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next       = state;
        s_cmd_ready      = 1'b0;
        m_ram_read_valid = 1'b0;
        case (state)
            IDLE: begin
                s_cmd_ready = !rst;
                if (s_cmd_valid && !rst) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                m_ram_read_valid = (credits != '0) && !rst;
                if ((credits != '0) && !rst && m_ram_read_ready && last_req) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign cmd_fire = s_cmd_valid && s_cmd_ready;
    assign req_fire = m_ram_read_valid && m_ram_read_ready;
    assign out_fire = m_valid && m_ready;

    assign m_ram_read_addr  = addr;
    assign m_ram_read_user  = (state == ISSUE) ? {last_req, tag} : '0;
    assign s_ram_read_ready = 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr  <= '0;
            count <= '0;
            tag   <= '0;
        end else if (cmd_fire) begin
            addr  <= s_cmd_addr;
            count <= s_cmd_len;
            tag   <= s_cmd_tag;
        end else if (req_fire) begin
            addr  <= addr + 1'b1;
            count <= count - 1'b1;
        end
    end

    // Each credit is one FIFO slot reserved for a request until its word leaves.
    always_ff @(posedge clk) begin
        if (rst) begin
            credits <= CREDITS_MAX;
        end else begin
            case ({req_fire, out_fire})
                2'b10:   credits <= credits - 1'b1;
                2'b01:   credits <= credits + 1'b1;
                default: credits <= credits;
            endcase
        end
    end

    // A response in the cycle right after reset belongs to a pre-reset request.
    always_ff @(posedge clk) begin
        rst_q <= rst;
    end

    assign fifo_wr_valid = s_ram_read_valid && !rst_q;
    assign fifo_wr_data  = {s_ram_read_data, s_ram_read_user[LAST_POS], s_ram_read_user[TAG_WIDTH-1:0]};

    stream_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_data  (fifo_wr_data),
        .wr_valid (fifo_wr_valid),
        .wr_ready (fifo_wr_ready),
        .rd_data  (fifo_rd_data),
        .rd_valid (m_valid),
        .rd_ready (m_ready)
    );

    assign {m_data, m_last, m_tag} = fifo_rd_data;

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(fifo_wr_valid && !fifo_wr_ready));
        end
    end

endmodule

// File: doc/ram_burst_reader.md
# ram_burst_reader

Read-side initiator for the block-RAM read port. Accepts burst read commands (start address, length, tag), issues one read request per word to the RAM's valid/ready read port, and collects the one-cycle-latency responses into a small FIFO. Delivers them downstream as a tagged stream with `last`. Issue is gated by credits, so the RAM's response path never needs backpressure. It sits between a lookup or DMA-style client and a RAM instance.

## Interface
- `ADDR_WIDTH`, 8: RAM address width.
- `DATA_WIDTH`, 8: RAM word width.
- `LEN_WIDTH`, 8: command length field width; a burst is `len+1` words.
- `TAG_WIDTH`, 4: command tag width.
- `FIFO_DEPTH`, 4: response FIFO entries; must be a power of two and ≥2. Full throughput requires ≥4.
- `USER_WIDTH` (derived), `TAG_WIDTH+1`: RAM user field, packed as {last, tag}.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `s_cmd_addr`  in  ADDR_WIDTH  burst start address.
- `s_cmd_len`  in  LEN_WIDTH  word count minus one.
- `s_cmd_tag`  in  TAG_WIDTH  tag echoed on every output word.
- `s_cmd_valid` / `s_cmd_ready`  in / out  1  command handshake.
- `m_ram_read_addr`  out  ADDR_WIDTH  read address to RAM.
- `m_ram_read_user`  out  USER_WIDTH  {last, tag} sent with the request.
- `m_ram_read_valid` / `m_ram_read_ready`  out / in  1  request handshake.
- `s_ram_read_data`  in  DATA_WIDTH  returned word.
- `s_ram_read_user`  in  USER_WIDTH  returned {last, tag}.
- `s_ram_read_valid`  in  1  response valid.
- `s_ram_read_ready`  out  1  constant 1; the FIFO space is reserved by the credit scheme.
- `m_data`  out  DATA_WIDTH  output word.
- `m_tag`  out  TAG_WIDTH  output tag.
- `m_last`  out  1  marks the final word of a burst.
- `m_valid` / `m_ready`  out / in  1  output handshake.

## Operation
- FSM with two states, IDLE and ISSUE.
  - In IDLE, `s_cmd_ready`=1. On accept, latch addr, remaining count = len, and tag, then go to ISSUE.
  - In ISSUE, `s_cmd_ready`=0. `m_ram_read_valid` = (credits>0).
  - On each request handshake: addr increments by 1, wrapping modulo 2^ADDR_WIDTH, and the count decrements.
  - The request issued with count==0 carries last=1; the FSM returns to IDLE on that handshake.
- Credit counter, range 0..FIFO_DEPTH, reset to FIFO_DEPTH:
  - −1 on each request handshake.
  - +1 on each output handshake.
  - Both in the same cycle: unchanged.
  - Invariant: in-flight + FIFO occupancy + credits = FIFO_DEPTH.
- Responses are written to the FIFO unconditionally when `s_ram_read_valid`=1. `m_tag` and `m_last` are unpacked from the returned user field.
- The FIFO never overflows. Writing while full is an assertion failure.
- Words are delivered in request order, and bursts never interleave.
- `m_ram_read_ready` low holds address, user and valid stable. No request is dropped or duplicated.
- Reset mid-burst:
  - FSM→IDLE, credits→FIFO_DEPTH, FIFO emptied.
  - A response arriving in the cycle after reset is discarded.

## Timing
- Reset values: `s_cmd_ready`=0 while `rst`=1, and 1 in the first cycle after release. `m_ram_read_valid`=0, `m_ram_read_addr`=0, `m_ram_read_user`=0, `m_valid`=0, `m_data`/`m_tag`/`m_last`=0. `s_ram_read_ready`=1.
- Command accepted at cycle T:
  - first request valid at T+1;
  - RAM response at T+2;
  - `m_valid` at T+3, from the registered FIFO output.
- With `m_ready`=1 and `m_ram_read_ready`=1, a burst streams at one word per cycle when FIFO_DEPTH≥4.
  - The credit loop is 3 cycles: issue → response → pop → credit visible.
- The next command is accepted the cycle after the last request handshake, giving one idle issue cycle between bursts.
- `m_valid` and the output fields hold while `m_ready`=0.

## Structure
- Package `ram_burst_reader_pkg` holds:
  - the state enum (IDLE, ISSUE);
  - localparams for the user-field bit positions (LAST_BIT = TAG_WIDTH, tag in [TAG_WIDTH-1:0]).
- Sub-module `stream_fifo`: synchronous FIFO with registered output and valid/ready on both sides, parameterised by width and depth. It is instantiated once with width DATA_WIDTH+TAG_WIDTH+1.
- The FSM, address/count registers and credit counter live in the top level.

## Test plan
- Single word:
  - Stimulus: cmd addr=0x10, len=0, tag=3, with the RAM preloaded so [0x10]=0xA5.
  - Required: one request with user={1,3}; `m_data`=0xA5, `m_tag`=3, `m_last`=1 at T+3.
- Streaming burst:
  - Stimulus: addr=0x20, len=7, `m_ready`=1.
  - Required: 8 consecutive output words, data [0x20..0x27], `m_last` only on the 8th.
- Address wrap:
  - Stimulus: addr=0xFE, len=3.
  - Required: requests to 0xFE, 0xFF, 0x00, 0x01.
- Downstream backpressure:
  - Stimulus: len=15 with `m_ready`=0 for 10 cycles.
  - Required: exactly FIFO_DEPTH requests issued, then `m_ram_read_valid`=0. After release, all 16 words arrive in order with no loss.
- RAM stall:
  - Stimulus: `m_ram_read_ready`=0 for 3 cycles mid-burst.
  - Required: address and user held stable, no duplicate words.
- Reset mid-burst:
  - Stimulus: `rst` pulsed after 3 of 8 requests.
  - Required: all outputs at reset values, credits=FIFO_DEPTH. A fresh command then completes correctly.
